pmem_line_responder: RTL and testbench



---
 rtl/pmem_line_responder.sv | 119 +++++++++++
 tb/tb_pmem_line_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Cycle-exact line memory behind the cache's pmem_* initiator port. Accepts one
//   128-bit line read or write at a time. Each access completes with a one-cycle
//   pmem_resp pulse exactly `latency` cycles after the request is first seen.
//
// Parameters
//   latency    cycles from request to pmem_resp. Legal range is 1..15.
//   line_bits  line-index width. The array holds 2**line_bits lines.
// Ports
//   clk            clock
//   reset          synchronous, active-high reset. The array contents are kept.
//   pmem_read      line read request, held until pmem_resp
//   pmem_write     line write request, held until pmem_resp. Wins over pmem_read.
//   pmem_address   byte address. The line index is [line_bits+3:4].
//   pmem_wdata     write line
//   pmem_rdata     registered read line. Holds until the next read completes.
//   pmem_resp      completion pulse
//   reads_served   saturating count of completed reads
//   writes_served  saturating count of completed writes
module pmem_line_responder #(
  parameter int unsigned latency   = 4,
  parameter int unsigned line_bits = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [15:0]  reads_served,
  output logic [15:0]  writes_served
);

  localparam int unsigned Lines     = 1 << line_bits;
  localparam logic [3:0]  LoadCount = 4'(latency - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q;
  logic                 op_write_q;
  logic [line_bits-1:0] idx_q;
  logic [127:0]         wdata_q;

  logic [127:0]         mem [Lines];

  logic                 req;
  logic [line_bits-1:0] req_idx;
  logic [line_bits-1:0] rd_idx;
  logic                 rd_is_read;
  logic                 unused_addr;

  assign req         = pmem_read | pmem_write;
  assign req_idx     = pmem_address[line_bits+3:4];
  // Offset bits and aliased upper bits are deliberately ignored.
  assign unused_addr = ^pmem_address;

  // With latency 1 the array is read on the accepting edge itself, so the
  // index and op come straight from the inputs rather than the latches.
  assign rd_idx     = (state_q == StIdle) ? req_idx : idx_q;
  assign rd_is_read = (state_q == StIdle) ? !pmem_write : !op_write_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req) state_d = (latency == 1) ? StResp : StBusy;
      StBusy: if (cnt_q <= 4'd1) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign pmem_resp = (state_q == StResp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      op_write_q    <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      pmem_rdata    <= '0;
      reads_served  <= 16'd0;
      writes_served <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req) begin
        op_write_q <= pmem_write;
        idx_q      <= req_idx;
        wdata_q    <= pmem_wdata;
        cnt_q      <= LoadCount;
      end else if (state_q == StBusy && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q != StResp && state_d == StResp && rd_is_read) begin
        pmem_rdata <= mem[rd_idx];
      end
      if (state_q == StResp) begin
        if (op_write_q) begin
          if (writes_served != 16'hFFFF) writes_served <= writes_served + 16'd1;
        end else begin
          if (reads_served != 16'hFFFF) reads_served <= reads_served + 16'd1;
        end
      end
    end
  end

  // Array has no reset; a reset in the RESP cycle discards the pending write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StResp && op_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

  localparam int LatA = 4;
  localparam int LatB = 1;

  logic         clk;
  logic         rst_s   [2];
  logic         rd_s    [2];
  logic         wr_s    [2];
  logic [15:0]  addr_s  [2];
  logic [127:0] wd_s    [2];
  logic [127:0] rdata_s [2];
  logic         resp_s  [2];
  logic [15:0]  rcnt_s  [2];
  logic [15:0]  wcnt_s  [2];

  int checks = 0;
  int errors = 0;

  pmem_line_responder #(.latency(LatA), .line_bits(8)) dut_a (
    .clk(clk), .reset(rst_s[0]), .pmem_read(rd_s[0]), .pmem_write(wr_s[0]),
    .pmem_address(addr_s[0]), .pmem_wdata(wd_s[0]), .pmem_rdata(rdata_s[0]),
    .pmem_resp(resp_s[0]), .reads_served(rcnt_s[0]), .writes_served(wcnt_s[0])
  );

  pmem_line_responder #(.latency(LatB), .line_bits(8)) dut_b (
    .clk(clk), .reset(rst_s[1]), .pmem_read(rd_s[1]), .pmem_write(wr_s[1]),
    .pmem_address(addr_s[1]), .pmem_wdata(wd_s[1]), .pmem_rdata(rdata_s[1]),
    .pmem_resp(resp_s[1]), .reads_served(rcnt_s[1]), .writes_served(wcnt_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each accepted request is simply a deadline `latency`
  // cycles after the cycle it was first seen; the array is a plain table.
  longint       cyc = 0;
  bit           m_valid [2];
  bit           m_busy  [2];
  longint       m_due   [2];
  bit           m_w     [2];
  logic [7:0]   m_idx   [2];
  logic [127:0] m_data  [2];
  logic [127:0] m_rdata [2];
  bit           m_rknown[2];
  int           m_rc    [2];
  int           m_wc    [2];
  bit           m_resp  [2];
  logic [127:0] mmem    [2][256];
  bit           mknown  [2][256];

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_s[i]) begin
          m_valid[i] = 1; m_busy[i] = 0; m_rdata[i] = '0; m_rknown[i] = 1;
          m_rc[i] = 0; m_wc[i] = 0;
        end else if (m_valid[i]) begin
          if (m_busy[i] && cyc == m_due[i]) begin
            m_busy[i] = 0;
            if (m_w[i]) begin
              mmem[i][m_idx[i]] = m_data[i];
              mknown[i][m_idx[i]] = 1;
              if (m_wc[i] < 65535) m_wc[i]++;
            end else if (m_rc[i] < 65535) begin
              m_rc[i]++;
            end
          end else if (!m_busy[i] && (rd_s[i] || wr_s[i])) begin
            m_busy[i] = 1;
            m_due[i]  = cyc + ((i == 0) ? LatA : LatB);
            m_w[i]    = wr_s[i];
            m_idx[i]  = addr_s[i][11:4];
            m_data[i] = wd_s[i];
          end
          if (m_busy[i] && m_due[i] == cyc + 1 && !m_w[i]) begin
            m_rdata[i]  = mmem[i][m_idx[i]];
            m_rknown[i] = mknown[i][m_idx[i]];
          end
        end
        m_resp[i] = m_busy[i] && (m_due[i] == cyc + 1);
      end
      cyc++;
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          chk($sformatf("u%0d_resp", i), 128'(resp_s[i]), 128'(m_resp[i]));
          chk($sformatf("u%0d_reads_served", i), 128'(rcnt_s[i]), 128'(m_rc[i]));
          chk($sformatf("u%0d_writes_served", i), 128'(wcnt_s[i]), 128'(m_wc[i]));
          if (m_rknown[i]) chk($sformatf("u%0d_rdata", i), rdata_s[i], m_rdata[i]);
        end
      end
    end
  end

  // One access: hold strobes until pmem_resp (or drop after drop_after cycles),
  // optionally scrambling address/data while the access is in flight.
  task automatic op(input int i, input logic r, input logic w, input logic [15:0] a,
                    input logic [127:0] d, input int drop_after, input bit scramble,
                    output int lat, output logic [127:0] rdv, output longint resp_cyc);
    int n;
    bit got;
    rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; wd_s[i] = d;
    n = 0; got = 0; lat = -1; rdv = '0; resp_cyc = -1;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == drop_after) begin rd_s[i] = 0; wr_s[i] = 0; end
      if (resp_s[i]) begin
        got = 1; lat = n; rdv = rdata_s[i]; resp_cyc = cyc;
      end else if (scramble) begin
        addr_s[i] = 16'($urandom);
        wd_s[i]   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    rd_s[i] = 0; wr_s[i] = 0;
    chk($sformatf("u%0d_resp_seen", i), 128'(got), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int i);
    rst_s[i] = 1;
    repeat (2) @(posedge clk);
    #1 rst_s[i] = 0;
  endtask

  localparam logic [127:0] Dead = 128'hDEADBEEF_00112233_44556677_8899AABB;

  initial begin
    int           lat, lat2, kind;
    logic [127:0] rdv, d;
    logic [15:0]  a;
    longint       t1, t2;

    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1; rd_s[i] = 0; wr_s[i] = 0; addr_s[i] = '0; wd_s[i] = '0;
    end
    rst_s[1] = 1;
    repeat (2) @(posedge clk);
    #1 rst_s[0] = 0; rst_s[1] = 0;

    // Quiet after reset.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("idle_resp", 128'(resp_s[0]), 128'(0));
      chk("idle_rdata", rdata_s[0], 128'(0));
      chk("idle_reads", 128'(rcnt_s[0]), 128'(0));
      chk("idle_writes", 128'(wcnt_s[0]), 128'(0));
    end

    // Write then read, latency 4.
    op(0, 0, 1, 16'h0120, Dead, 0, 0, lat, rdv, t1);
    chk("wr_latency", 128'(lat), 128'(4));
    op(0, 1, 0, 16'h012E, '0, 0, 0, lat, rdv, t1);
    chk("rd_latency", 128'(lat), 128'(4));
    chk("rd_data", rdv, Dead);
    chk("wr_count_1", 128'(wcnt_s[0]), 128'(1));
    chk("rd_count_1", 128'(rcnt_s[0]), 128'(1));

    // Aliasing and offset bits.
    op(0, 0, 1, 16'h0010, 128'hAAAA_0001, 0, 0, lat, rdv, t1);
    op(0, 0, 1, 16'h1010, 128'hBBBB_0002, 0, 0, lat, rdv, t1);
    op(0, 1, 0, 16'h001F, '0, 0, 0, lat, rdv, t1);
    chk("alias_data", rdv, 128'hBBBB_0002);

    // Simultaneous strobes: write wins.
    op(0, 1, 1, 16'h0040, 128'h5151_4040, 0, 0, lat, rdv, t1);
    chk("both_latency", 128'(lat), 128'(4));
    chk("both_writes", 128'(wcnt_s[0]), 128'(4));
    chk("both_reads", 128'(rcnt_s[0]), 128'(2));
    op(0, 1, 0, 16'h0040, '0, 0, 0, lat, rdv, t1);
    chk("both_readback", rdv, 128'h5151_4040);

    // Reset two cycles after accepting a write.
    op(0, 0, 1, 16'h0050, 128'h0050_0001, 0, 0, lat, rdv, t1);
    wr_s[0] = 1; addr_s[0] = 16'h0050; wd_s[0] = 128'h0050_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_s[0] = 1; wr_s[0] = 0;
    @(posedge clk); #1;
    rst_s[0] = 0;
    chk("rst_resp", 128'(resp_s[0]), 128'(0));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rst_no_resp", 128'(resp_s[0]), 128'(0));
    end
    chk("rst_writes", 128'(wcnt_s[0]), 128'(0));
    chk("rst_reads", 128'(rcnt_s[0]), 128'(0));
    op(0, 1, 0, 16'h0050, '0, 0, 0, lat, rdv, t1);
    chk("rst_prewrite_data", rdv, 128'h0050_0001);

    // Latency 1, back-to-back reads.
    op(1, 0, 1, 16'h0000, 128'hC0C0_0000, 0, 0, lat, rdv, t1);
    op(1, 0, 1, 16'h0010, 128'hC1C1_0010, 0, 0, lat, rdv, t1);
    op(1, 1, 0, 16'h0000, '0, 0, 0, lat, rdv, t1);
    chk("l1_lat_a", 128'(lat), 128'(1));
    chk("l1_data_a", rdv, 128'hC0C0_0000);
    op(1, 1, 0, 16'h0010, '0, 0, 0, lat2, rdv, t2);
    chk("l1_lat_b", 128'(lat2), 128'(1));
    chk("l1_data_b", rdv, 128'hC1C1_0010);
    chk("l1_spacing", 128'(t2 - t1), 128'(2));
    chk("l1_reads", 128'(rcnt_s[1]), 128'(2));

    // Randomized traffic on both instances, checked against the model.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 60; n++) begin
        kind = int'($urandom_range(0, 2));
        a = {4'($urandom), 4'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
        d = {$urandom, $urandom, $urandom, $urandom};
        op(i, kind != 1, kind != 0, a, d, int'($urandom_range(0, 3)), 1, lat, rdv, t1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
